// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg: shared encodings for the MIPS load/store unit.
package mips_lsu_pkg;

    // Default number of 32-bit words in the data memory
    localparam int unsigned DM_DEPTH_DEFAULT = 512;

    // Request size encodings
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Request fields captured at acceptance
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [1:0]  offset;
        logic [31:0] wdata;
    } lsu_req_t;

    // Byte offset inside the word after forcing natural alignment
    function automatic logic [1:0] lane_offset(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [1:0] off;
        case (size)
            SZ_BYTE: off = addr_lo;
            SZ_HALF: off = {addr_lo[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: big-endian lane extraction/extension for loads and
// lane merge for sub-word stores. Purely combinational.
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/halfword and extend it for the load result
    always_comb begin
        byte_sel = '0;
        ld_data  = '0;
        case (offset)
            2'd0:    byte_sel = rd_word[31:24];
            2'd1:    byte_sel = rd_word[23:16];
            2'd2:    byte_sel = rd_word[15:8];
            default: byte_sel = rd_word[7:0];
        endcase
        half_sel = offset[1] ? rd_word[15:0] : rd_word[31:16];
        case (size)
            SZ_BYTE: ld_data = is_unsigned ? {24'd0, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_data = is_unsigned ? {16'd0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            default: ld_data = rd_word;
        endcase
    end

    // Replace the addressed lane of the fetched word with the store data
    always_comb begin
        st_word = rd_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    st_word[31:24] = st_data[7:0];
                    2'd1:    st_word[23:16] = st_data[7:0];
                    2'd2:    st_word[15:8]  = st_data[7:0];
                    default: st_word[7:0]   = st_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) st_word[15:0]  = st_data[15:0];
                else           st_word[31:16] = st_data[15:0];
            end
            default: st_word = st_data;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit driving the word-addressed MIPS data memory.
// Sub-word stores are done as read-modify-write (memory has no byte enables).
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests return
// resp_err instead of being forced to alignment.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int unsigned DM_DEPTH = DM_DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_address,
    output logic [31:0] dm_write_data,
    output logic        dm_mem_write,
    output logic        dm_mem_read,
    input  logic [31:0] dm_read_data
);

    logic [1:0]  state;
    lsu_req_t    req_q;
    logic        misalign;
    logic        out_of_range;
    logic        req_error;
    logic [31:0] word_index;
    logic [31:0] ld_data;
    logic [31:0] st_word;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign word_index   = {2'b00, req_addr[31:2]};
    assign out_of_range = (word_index >= DM_DEPTH);
    assign req_error    = (req_size == SZ_ILLEGAL) || out_of_range || misalign;

    mips_lsu_align u_align (
        .rd_word     (dm_read_data),
        .size        (req_q.size),
        .offset      (req_q.offset),
        .is_unsigned (req_q.is_unsigned),
        .st_data     (req_q.wdata),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    // Request FSM; every output is a register updated here
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            req_q         <= '0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            dm_address    <= '0;
            dm_write_data <= '0;
            dm_mem_write  <= 1'b0;
            dm_mem_read   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready         <= 1'b0;
                        req_q.we          <= req_we;
                        req_q.size        <= req_size;
                        req_q.is_unsigned <= req_unsigned;
                        req_q.offset      <= lane_offset(req_size, req_addr[1:0]);
                        req_q.wdata       <= req_wdata;
                        if (req_error) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_we || (req_size != SZ_WORD)) begin
                            state       <= ST_RD;
                            dm_address  <= word_index;
                            dm_mem_read <= 1'b1;
                        end else begin
                            state         <= ST_WR;
                            dm_address    <= word_index;
                            dm_write_data <= req_wdata;
                            dm_mem_write  <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    // read data was captured by memory on the negedge of this cycle
                    dm_mem_read <= 1'b0;
                    if (req_q.we) begin
                        state         <= ST_WR;
                        dm_write_data <= st_word;
                        dm_mem_write  <= 1'b1;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= ld_data;
                    end
                end
                ST_WR: begin
                    dm_mem_write <= 1'b0;
                    state        <= ST_RESP;
                    resp_valid   <= 1'b1;
                    resp_err     <= 1'b0;
                    resp_rdata   <= '0;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: directed self-checking bench for mips_lsu with a behavioural
// MIPSDM-style memory (read captured on negedge, write on posedge).
module tb_mips_lsu;
    import mips_lsu_pkg::*;

    localparam int unsigned DEPTH = 512;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic        dm_mem_write;
    logic        dm_mem_read;
    logic [31:0] dm_read_data = '0;

    logic [31:0] mem [0:DEPTH-1];
    logic        pl_en = 1'b0;
    logic [8:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;
    logic [31:0] last_wdata = '0;

    mips_lsu #(.DM_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_address(dm_address),
        .dm_write_data(dm_write_data), .dm_mem_write(dm_mem_write),
        .dm_mem_read(dm_mem_read), .dm_read_data(dm_read_data)
    );

    always #5 clock = ~clock;

    // Memory write port (plus bench preload)
    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (dm_mem_write && !dm_mem_read && dm_address < DEPTH)
            mem[dm_address[8:0]] <= dm_write_data;
    end

    // Memory read port and strobe monitor
    always @(negedge clock) begin
        if (dm_mem_read && !dm_mem_write && dm_address < DEPTH)
            dm_read_data <= mem[dm_address[8:0]];
        if (dm_mem_read) rd_cnt++;
        if (dm_mem_write) begin
            wr_cnt++;
            last_wdata = dm_write_data;
        end
        if (dm_mem_read && dm_mem_write) both_cnt++;
    end

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    // Present a request until accepted; afterwards scramble req_* fields
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output bit ok);
        int n = 0;
        while (!req_ready && n < 20) begin @(posedge clock); #1; n++; end
        ok = req_ready;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clock); #1;
        req_valid = 1'b0; req_we = ~we; req_size = size ^ 2'b01;
        req_unsigned = ~uns; req_addr = 32'h0000_0FFC; req_wdata = ~wdata;
    endtask

    // Cycles from acceptance edge until resp_valid (1 = set at acceptance edge)
    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (!resp_valid && cyc < 20) begin @(posedge clock); #1; cyc++; end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        checks++; if ({req_ready, resp_valid, resp_err, dm_mem_write, dm_mem_read} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000",
                {req_ready, resp_valid, resp_err, dm_mem_write, dm_mem_read}); end
        checks++; if ({resp_rdata, dm_address, dm_write_data} !== 96'd0) begin
            errors++; $display("FAIL reset_data got %h %h %h want 0",
                resp_rdata, dm_address, dm_write_data); end
        reset_n = 1'b1;
        @(posedge clock); #1;
        checks++; if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_word_load();
        bit ok; int cyc; int r0; int w0;
        preload(9'd5, 32'd7);
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lw_accept got 0 want 1"); end
        checks++; if (dm_address !== 32'd5) begin
            errors++; $display("FAIL lw_addr got %h want 5", dm_address); end
        wait_resp(cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", cyc); end
        checks++; if (resp_rdata !== 32'h7 || resp_err !== 1'b0) begin
            errors++; $display("FAIL lw_data got %h err %b want 00000007 err 0", resp_rdata, resp_err); end
        checks++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0) begin
            errors++; $display("FAIL lw_strobes got rd %0d wr %0d want 1 0", rd_cnt - r0, wr_cnt - w0); end
        finish_resp();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL lw_done got ready %b valid %b want 1 0", req_ready, resp_valid); end
    endtask

    task automatic test_subword_load();
        bit ok; int cyc;
        logic [1:0]  sz  [5] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE};
        logic        un  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ad  [5] = '{32'h0, 32'h1, 32'h2, 32'h0, 32'h3};
        logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h000000FF, 32'h00001234,
                                 32'hFFFF80FF, 32'h00000034};
        preload(9'd0, 32'h80FF1234);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, sz[i], un[i], ad[i], 32'h0, ok);
            wait_resp(cyc);
            checks++; if (resp_rdata !== exp[i] || cyc !== 2 || !ok) begin
                errors++; $display("FAIL subload_%0d got %h lat %0d want %h lat 2",
                    i, resp_rdata, cyc, exp[i]); end
            finish_resp();
        end
    endtask

    task automatic test_subword_store();
        bit ok; int cyc; int r0; int w0;
        preload(9'd3, 32'h11223344);
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b1, SZ_BYTE, 1'b0, 32'hD, 32'h000000AA, ok);
        checks++; if (dm_mem_read !== 1'b1 || dm_mem_write !== 1'b0) begin
            errors++; $display("FAIL sb_rd_phase got rd %b wr %b want 1 0", dm_mem_read, dm_mem_write); end
        @(posedge clock); #1;
        checks++; if (dm_mem_read !== 1'b0 || dm_mem_write !== 1'b1 || dm_write_data !== 32'h11AA3344) begin
            errors++; $display("FAIL sb_wr_phase got rd %b wr %b data %h want 0 1 11aa3344",
                dm_mem_read, dm_mem_write, dm_write_data); end
        wait_resp(cyc);
        cyc = cyc + 1;
        checks++; if (cyc !== 3) begin errors++; $display("FAIL sb_latency got %0d want 3", cyc); end
        checks++; if (mem[3] !== 32'h11AA3344 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL sb_commit got mem %h rdata %h err %b want 11aa3344 0 0",
                mem[3], resp_rdata, resp_err); end
        checks++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1 || last_wdata !== 32'h11AA3344) begin
            errors++; $display("FAIL sb_strobes got rd %0d wr %0d data %h want 1 1 11aa3344",
                rd_cnt - r0, wr_cnt - w0, last_wdata); end
        finish_resp();
        issue(1'b0, SZ_WORD, 1'b0, 32'hC, 32'h0, ok);
        wait_resp(cyc);
        checks++; if (resp_rdata !== 32'h11AA3344) begin
            errors++; $display("FAIL sb_readback got %h want 11aa3344", resp_rdata); end
        finish_resp();
        issue(1'b1, SZ_HALF, 1'b0, 32'hE, 32'hFFFFBEEF, ok);
        wait_resp(cyc);
        finish_resp();
        checks++; if (mem[3] !== 32'h11AABEEF) begin
            errors++; $display("FAIL sh_commit got %h want 11aabeef", mem[3]); end
        issue(1'b0, SZ_HALF, 1'b1, 32'hE, 32'h0, ok);
        wait_resp(cyc);
        checks++; if (resp_rdata !== 32'h0000BEEF) begin
            errors++; $display("FAIL lhu_readback got %h want 0000beef", resp_rdata); end
        finish_resp();
    endtask

    task automatic test_word_store();
        bit ok; int cyc; int r0; int w0;
        preload(9'd8, 32'h0);
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEADBEEF, ok);
        checks++; if (dm_mem_write !== 1'b1 || dm_write_data !== 32'hDEADBEEF || dm_address !== 32'd8) begin
            errors++; $display("FAIL sw_phase got wr %b data %h addr %h want 1 deadbeef 8",
                dm_mem_write, dm_write_data, dm_address); end
        wait_resp(cyc);
        checks++; if (cyc !== 2 || mem[8] !== 32'hDEADBEEF || rd_cnt - r0 !== 0 || wr_cnt - w0 !== 1) begin
            errors++; $display("FAIL sw_commit got lat %0d mem %h rd %0d wr %0d want 2 deadbeef 0 1",
                cyc, mem[8], rd_cnt - r0, wr_cnt - w0); end
        finish_resp();
    endtask

    task automatic test_errors();
        bit ok; int cyc; int r0; int w0;
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b0, SZ_WORD, 1'b0, 32'h800, 32'h0, ok);
        wait_resp(cyc);
        checks++; if (cyc !== 1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++; $display("FAIL err_range got lat %0d err %b data %h want 1 1 0", cyc, resp_err, resp_rdata); end
        finish_resp();
        issue(1'b1, SZ_ILLEGAL, 1'b0, 32'h0, 32'h5, ok);
        wait_resp(cyc);
        checks++; if (cyc !== 1 || resp_err !== 1'b1) begin
            errors++; $display("FAIL err_size got lat %0d err %b want 1 1", cyc, resp_err); end
        finish_resp();
        checks++; if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) begin
            errors++; $display("FAIL err_strobes got rd %0d wr %0d want 0 0", rd_cnt - r0, wr_cnt - w0); end
        preload(9'd511, 32'hCAFEF00D);
        issue(1'b0, SZ_WORD, 1'b0, 32'h7FC, 32'h0, ok);
        wait_resp(cyc);
        checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL last_word got err %b data %h want 0 cafef00d", resp_err, resp_rdata); end
        finish_resp();
        issue(1'b0, SZ_WORD, 1'b0, 32'h16, 32'h0, ok);
        wait_resp(cyc);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (resp_err !== 1'b1 || cyc !== 1) begin
            errors++; $display("FAIL misalign_word got err %b lat %0d want 1 1", resp_err, cyc); end
`else
        checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h7) begin
            errors++; $display("FAIL misalign_word got err %b data %h want 0 00000007", resp_err, resp_rdata); end
`endif
        finish_resp();
        issue(1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0, ok);
        wait_resp(cyc);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (resp_err !== 1'b1) begin
            errors++; $display("FAIL misalign_half got err %b want 1", resp_err); end
`else
        checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h00001234) begin
            errors++; $display("FAIL misalign_half got err %b data %h want 0 00001234", resp_err, resp_rdata); end
`endif
        finish_resp();
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; bit bad = 1'b0;
        issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, ok);
        wait_resp(cyc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h7 || req_ready !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin
            errors++; $display("FAIL hold_stable got valid %b data %h ready %b want 1 7 0",
                resp_valid, resp_rdata, req_ready); end
        finish_resp();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release got ready %b valid %b want 1 0", req_ready, resp_valid); end
        issue(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, ok);
        wait_resp(cyc);
        checks++; if (!ok || resp_rdata !== 32'h80FF1234) begin
            errors++; $display("FAIL hold_next got %h want 80ff1234", resp_rdata); end
        finish_resp();
    endtask

    task automatic test_reset_mid();
        bit ok; bit seen = 1'b0;
        issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, ok);
        reset_n = 1'b0;
        @(posedge clock); #1;
        checks++; if ({req_ready, resp_valid, resp_err, dm_mem_write, dm_mem_read, resp_rdata, dm_address, dm_write_data} !== '0) begin
            errors++; $display("FAIL rst_rd_clear got %b%b%b%b%b %h %h %h want all 0",
                req_ready, resp_valid, resp_err, dm_mem_write, dm_mem_read, resp_rdata, dm_address, dm_write_data); end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (resp_valid) seen = 1'b1;
        end
        checks++; if (seen || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_rd_noresp got seen %b ready %b want 0 1", seen, req_ready); end
        preload(9'd9, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h24, 32'h12345678, ok);
        reset_n = 1'b0;
        @(posedge clock); #1;
        checks++; if (mem[9] !== 32'h12345678 || dm_mem_write !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_wr_commit got mem %h wr %b valid %b want 12345678 0 0",
                mem[9], dm_mem_write, resp_valid); end
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_word_load();
        test_subword_load();
        test_subword_store();
        test_word_store();
        test_errors();
        test_backpressure();
        test_reset_mid();
        checks++; if (both_cnt !== 0) begin
            errors++; $display("FAIL strobe_overlap got %0d want 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
